spi: RTL and testbench
======================

SPI -- requirements
Module: spi

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter RST_CYCLES, default 8: clk cycles LCD_reset stays low after nrst deasserts; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 data  input  8  byte to transmit, sampled on the accept edge.
REQ-006 mode  input  1  D/C select, sampled on the accept edge: 1 = data, 0 = command.
REQ-007 enable  input  1  transfer request, level-sensitive.
REQ-008 ready  output  1  high = idle and able to accept a byte.
REQ-009 SCK  output  1  serial clock, idle low.
REQ-010 MOSI  output  1  serial data, MSB first.
REQ-011 DC  output  1  latched mode, driven to the LCD D/C pin.
REQ-012 CS  output  1  active-low chip select.
REQ-013 LCD_reset  output  1  active-low LCD reset.

Function
REQ-014 All outputs SHALL be registered, with no combinational input-to-output paths.
REQ-015 The FSM SHALL have states INIT, IDLE, SHIFT and DONE.
REQ-016 INIT: LCD_reset=0, ready=0, CS=1, SCK=0; after RST_CYCLES clocks, LCD_reset<=1, ready<=1, go to IDLE.
REQ-017 IDLE: ready=1, CS=1, SCK=0; enable=1 at a rising edge is the accept edge.
REQ-018 On the accept edge: shift register<=data, DC<=mode, MOSI<=data[7], CS<=0, ready<=0, bit counter<=7, go to SHIFT.
REQ-019 enable SHALL be ignored while ready=0; data and mode changes after the accept edge SHALL NOT affect the transfer in flight.
REQ-020 SHIFT: each bit SHALL take 2*CLK_DIV clocks: SCK low for CLK_DIV clocks, then high for CLK_DIV clocks (SPI mode 0, CPOL=0, CPHA=0).
REQ-021 MOSI SHALL change only on the edge where SCK goes low, or on the accept edge for bit 7, so it is stable across every SCK rising edge.
REQ-022 Bit order SHALL be data[7] down to data[0], exactly 8 SCK rising edges per transfer.
REQ-023 After the bit-0 high phase: SCK<=0 and go to DONE; this SHALL occur 16*CLK_DIV clocks after the accept edge.
REQ-024 DONE, one clock: CS<=1, ready<=1, MOSI<=0, go to IDLE; ready=0 SHALL last exactly 16*CLK_DIV+1 clocks.
REQ-025 DC SHALL hold its value from the accept edge until the next accept edge.
REQ-026 enable held high continuously SHALL start the next byte on the first edge where ready=1; back-to-back transfers are permitted.
REQ-027 SCK SHALL never glitch, and CS SHALL never toggle mid-byte.

Reset
REQ-028 nrst=0 SHALL immediately force: ready=0, SCK=0, MOSI=0, CS=1, DC=0, LCD_reset=0, counters cleared, state INIT.
REQ-029 Reset mid-transfer SHALL abort the byte without completing it; after release the INIT sequence SHALL repeat before ready rises.
REQ-030 ready SHALL rise exactly RST_CYCLES clocks after nrst deasserts.

Verification
REQ-031 Reset release -> LCD_reset=0 and ready=0 for 8 clocks, then both 1; CS=1 and SCK=0 throughout.
REQ-032 data=0xA5, mode=1, enable pulse -> MOSI at SCK rises = 1,0,1,0,0,1,0,1; DC=1; CS low; ready low 65 clocks.
REQ-033 data=0x3C, mode=0 -> MOSI = 0,0,1,1,1,1,0,0; DC=0; exactly 8 SCK pulses of 4 high / 4 low clocks.
REQ-034 data changed to 0xFF and mode toggled during a 0x00 transfer -> all 8 MOSI bits 0, DC unchanged.
REQ-035 nrst pulsed low during bit 4 -> CS=1, SCK=0, LCD_reset=0 immediately; INIT repeats; the next byte transfers intact.
REQ-036 10 random bytes/modes, enable released after ready falls -> each byte and DC match a scoreboard; CS high at least 1 clock between bytes.

Source files
------------

// File: rtl/spi.sv
// ---------------------------------------------------------------------------
// spi -- write-only SPI master for an LCD controller (SPI mode 0).
//
// After reset release the block holds LCD_reset low for RST_CYCLES clocks,
// then raises LCD_reset and ready together. Each byte is shifted out MSB
// first on MOSI with CS low. Every bit lasts 2*CLK_DIV clocks: SCK is low for
// CLK_DIV clocks, then high for CLK_DIV clocks. DC carries the D/C flag
// latched when the byte was accepted.
//
// Handshake: ready=1 means the block is idle. A rising clk edge with
// ready=1 and enable=1 is the accept edge: data and mode are captured on
// that edge and ready drops on the same edge. enable is ignored while
// ready=0. ready stays low for exactly 16*CLK_DIV+1 clocks per byte. If
// enable is still high on the first edge with ready=1, the next byte is
// accepted on that edge (back-to-back transfers).
//
// Parameters:
//   CLK_DIV     SCK half-period in clk cycles, 1..255
//   RST_CYCLES  clk cycles LCD_reset stays low after nrst rises, 1..65535
//
// Ports:
//   clk          in   system clock, rising edge
//   nrst         in   asynchronous active-low reset
//   data[7:0]    in   byte to send, captured on the accept edge
//   mode         in   D/C flag, captured on the accept edge (1 = data)
//   enable       in   transfer request, level sensitive
//   ready        out  idle and able to accept a byte
//   SCK          out  serial clock, idle low
//   MOSI         out  serial data, MSB first
//   DC           out  latched D/C flag
//   CS           out  active-low chip select
//   LCD_reset    out  active-low LCD reset
//   dbg_state_o  out  FSM state: 0 = INIT, 1 = IDLE, 2 = SHIFT, 3 = DONE
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module spi #(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] data,
    input  logic       mode,
    input  logic       enable,
    output logic       ready,
    output logic       SCK,
    output logic       MOSI,
    output logic       DC,
    output logic       CS,
    output logic       LCD_reset,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    // Only data[6:0] is kept: data[7] goes straight to MOSI on the accept edge.
    logic [6:0]  sr_q, sr_d;
    logic        ready_q, ready_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        dc_q, dc_d;
    logic        cs_q, cs_d;
    logic        lcd_rst_q, lcd_rst_d;

    logic init_done;
    logic div_last;
    logic byte_end;

    assign init_done = (rst_cnt_q == RST_LAST);
    assign div_last  = (div_cnt_q == DIV_LAST);
    // End of the bit-0 high phase: the last half-period of the byte.
    assign byte_end  = div_last && sck_q && (bit_cnt_q == 3'd0);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:  if (init_done) state_d = ST_IDLE;
            ST_IDLE:  if (enable)    state_d = ST_SHIFT;
            ST_SHIFT: if (byte_end)  state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_INIT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values. Everything defaults to hold so outputs
    // only move on the edges named below.
    // -----------------------------------------------------------------------
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        ready_d   = ready_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        dc_d      = dc_q;
        cs_d      = cs_q;
        lcd_rst_d = lcd_rst_q;

        unique case (state_q)
            ST_INIT: begin
                if (init_done) begin
                    rst_cnt_d = '0;
                    ready_d   = 1'b1;
                    lcd_rst_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 16'd1;
                end
            end

            ST_IDLE: begin
                if (enable) begin
                    sr_d      = data[6:0];
                    dc_d      = mode;
                    mosi_d    = data[7];
                    cs_d      = 1'b0;
                    ready_d   = 1'b0;
                    bit_cnt_d = 3'd7;
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        // Low phase over: rising SCK, MOSI already stable.
                        sck_d = 1'b1;
                    end else if (bit_cnt_q == 3'd0) begin
                        // Last bit done; MOSI is cleared in DONE.
                        sck_d = 1'b0;
                    end else begin
                        // Falling SCK is the only place MOSI advances.
                        sck_d     = 1'b0;
                        mosi_d    = sr_q[6];
                        sr_d      = {sr_q[5:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                cs_d    = 1'b1;
                ready_d = 1'b1;
                mosi_d  = 1'b0;
            end

            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rst_cnt_q <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            ready_q   <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
            cs_q      <= 1'b1;
            lcd_rst_q <= 1'b0;
        end else begin
            rst_cnt_q <= rst_cnt_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            ready_q   <= ready_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            dc_q      <= dc_d;
            cs_q      <= cs_d;
            lcd_rst_q <= lcd_rst_d;
        end
    end

    assign ready       = ready_q;
    assign SCK         = sck_q;
    assign MOSI        = mosi_q;
    assign DC          = dc_q;
    assign CS          = cs_q;
    assign LCD_reset   = lcd_rst_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi.sv
// ---------------------------------------------------------------------------
// tb_spi -- self-checking bench for spi (CLK_DIV=4, RST_CYCLES=8).
// Inputs change on the falling clock edge; outputs are sampled there too.
// Expected values come from the byte/mode that was sent and the timing
// rules: 8 SCK rises, MSB first, CLK_DIV-wide SCK phases, 16*CLK_DIV+1
// ready-low clocks, RST_CYCLES clocks from reset release to ready.
// ---------------------------------------------------------------------------
module tb_spi;

  localparam int D      = 4;
  localparam int R      = 8;
  localparam int LOW_EXP = 16 * D + 1;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       mode = 1'b0;
  logic       enable = 1'b0;
  logic       ready, SCK, MOSI, DC, CS, LCD_reset;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  spi #(.CLK_DIV(D), .RST_CYCLES(R)) dut (
    .clk(clk), .nrst(nrst), .data(data), .mode(mode), .enable(enable),
    .ready(ready), .SCK(SCK), .MOSI(MOSI), .DC(DC), .CS(CS),
    .LCD_reset(LCD_reset), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Caller is at a falling edge. Waits (bounded) until ready is high.
  task automatic wait_ready(output int waited);
    waited = 0;
    while (ready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Releases nrst at the current falling edge and reports the clock edge
  // number at which ready first reads high, plus samples where the INIT
  // outputs were wrong.
  task automatic release_reset(output int rise_at, output int bad, output logic lcd_at_rise);
    rise_at = -1;
    bad = 0;
    lcd_at_rise = 1'b0;
    nrst = 1'b1;
    for (int k = 1; k <= R + 20; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        rise_at = k;
        lcd_at_rise = LCD_reset;
        break;
      end
      if (LCD_reset !== 1'b0 || CS !== 1'b1 || SCK !== 1'b0) bad++;
    end
  endtask

  // Sends one byte and records what appeared on the wire until ready rises.
  task automatic do_transfer(
    input  logic [7:0] d, input logic m, input bit hold, input bit corrupt,
    output logic [7:0] got, output int rises, output int low_cycles,
    output int width_bad, output int mosi_bad, output int cs_bad,
    output int dc_bad, output int waited, output logic cs_after
  );
    logic prev_sck, prev_mosi;
    int run;
    bit first;
    wait_ready(waited);
    data = d;
    mode = m;
    enable = 1'b1;
    @(posedge clk);
    got = 8'h00; rises = 0; low_cycles = 0; width_bad = 0;
    mosi_bad = 0; cs_bad = 0; dc_bad = 0;
    prev_sck = 1'b0; prev_mosi = 1'b0; run = 0; first = 1'b1;
    for (int i = 0; i < 16 * 256 + 8; i++) begin
      @(negedge clk);
      if (!hold) enable = 1'b0;
      if (ready === 1'b1) break;
      low_cycles++;
      if (CS !== 1'b0) cs_bad++;
      if (DC !== m) dc_bad++;
      if (SCK === 1'b1 && prev_sck === 1'b0) begin
        got = {got[6:0], MOSI};
        rises++;
      end
      if (!first && MOSI !== prev_mosi && !(SCK === 1'b0 && prev_sck === 1'b1)) mosi_bad++;
      if (SCK === prev_sck) run++;
      else begin
        if (run != D) width_bad++;
        run = 1;
      end
      prev_sck = SCK;
      prev_mosi = MOSI;
      first = 1'b0;
      if (corrupt) begin
        data = 8'hFF;
        mode = ~m;
      end
    end
    cs_after = CS;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int rise_at, bad;
    logic lcd_at_rise;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || SCK !== 1'b0 || MOSI !== 1'b0 || CS !== 1'b1 || DC !== 1'b0 || LCD_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b SCK=%b MOSI=%b CS=%b DC=%b LCD_reset=%b, need 0 0 0 1 0 0",
               ready, SCK, MOSI, CS, DC, LCD_reset);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d need 0 (INIT)", dbg_state);
    end
    release_reset(rise_at, bad, lcd_at_rise);
    checks++;
    if (rise_at != R) begin
      errors++;
      $display("FAIL reset_ready_rise: got edge %0d need %0d", rise_at, R);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_init_outputs: got %0d bad samples need 0", bad);
    end
    checks++;
    if (lcd_at_rise !== 1'b1) begin
      errors++;
      $display("FAIL reset_lcd_rise: got %b need 1", lcd_at_rise);
    end
  endtask

  task automatic test_pattern(input logic [7:0] d, input logic m);
    logic [7:0] got;
    int rises, low, wb, mb, cb, db, waited;
    logic cs_after;
    do_transfer(d, m, 1'b0, 1'b0, got, rises, low, wb, mb, cb, db, waited, cs_after);
    checks++;
    if (got !== d) begin errors++; $display("FAIL pattern_bits: got %h need %h", got, d); end
    checks++;
    if (rises != 8) begin errors++; $display("FAIL pattern_rises: got %0d need 8", rises); end
    checks++;
    if (low != LOW_EXP) begin errors++; $display("FAIL pattern_ready_low: got %0d need %0d", low, LOW_EXP); end
    checks++;
    if (wb != 0) begin errors++; $display("FAIL pattern_sck_width: got %0d bad phases need 0", wb); end
    checks++;
    if (mb != 0) begin errors++; $display("FAIL pattern_mosi_stable: got %0d bad changes need 0", mb); end
    checks++;
    if (cb != 0 || cs_after !== 1'b1) begin
      errors++;
      $display("FAIL pattern_cs: got %0d low-phase errors, after=%b need 0, 1", cb, cs_after);
    end
    checks++;
    if (db != 0 || DC !== m) begin errors++; $display("FAIL pattern_dc: got DC=%b errs=%0d need %b", DC, db, m); end
  endtask

  task automatic test_data_change();
    logic [7:0] got;
    int rises, low, wb, mb, cb, db, waited;
    logic cs_after;
    do_transfer(8'h00, 1'b1, 1'b0, 1'b1, got, rises, low, wb, mb, cb, db, waited, cs_after);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL change_bits: got %h need 00", got); end
    checks++;
    if (db != 0 || DC !== 1'b1) begin errors++; $display("FAIL change_dc: got DC=%b errs=%0d need 1", DC, db); end
    checks++;
    if (low != LOW_EXP) begin errors++; $display("FAIL change_ready_low: got %0d need %0d", low, LOW_EXP); end
    data = 8'h00;
    mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited, rise_at, bad;
    logic lcd_at_rise;
    logic [7:0] got;
    int rises, low, wb, mb, cb, db;
    logic cs_after;
    wait_ready(waited);
    data = 8'h96;
    mode = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    // Land inside bit 4 (the fourth bit sent): clocks 6*D..8*D after accept.
    repeat (7 * D - 1) @(negedge clk);
    checks++;
    if (CS !== 1'b0) begin errors++; $display("FAIL midrst_inflight_cs: got %b need 0", CS); end
    nrst = 1'b0;
    #1;
    checks++;
    if (CS !== 1'b1 || SCK !== 1'b0 || LCD_reset !== 1'b0 || ready !== 1'b0 || MOSI !== 1'b0 || DC !== 1'b0) begin
      errors++;
      $display("FAIL midrst_immediate: got CS=%b SCK=%b LCD_reset=%b ready=%b MOSI=%b DC=%b need 1 0 0 0 0 0",
               CS, SCK, LCD_reset, ready, MOSI, DC);
    end
    repeat (2) @(negedge clk);
    release_reset(rise_at, bad, lcd_at_rise);
    checks++;
    if (rise_at != R || bad != 0 || lcd_at_rise !== 1'b1) begin
      errors++;
      $display("FAIL midrst_init: got rise edge %0d bad %0d lcd %b need %0d 0 1", rise_at, bad, lcd_at_rise, R);
    end
    do_transfer(8'h5A, 1'b0, 1'b0, 1'b0, got, rises, low, wb, mb, cb, db, waited, cs_after);
    checks++;
    if (got !== 8'h5A || rises != 8 || low != LOW_EXP || DC !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next_byte: got %h rises %0d low %0d DC %b need 5a 8 %0d 0", got, rises, low, DC, LOW_EXP);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got1, got2;
    int rises, low1, low2, wb, mb, cb, db, waited1, waited2;
    logic cs_after;
    do_transfer(8'hC3, 1'b0, 1'b1, 1'b0, got1, rises, low1, wb, mb, cb, db, waited1, cs_after);
    do_transfer(8'h81, 1'b1, 1'b0, 1'b0, got2, rises, low2, wb, mb, cb, db, waited2, cs_after);
    checks++;
    if (got1 !== 8'hC3 || low1 != LOW_EXP) begin
      errors++;
      $display("FAIL b2b_first: got %h low %0d need c3 %0d", got1, low1, LOW_EXP);
    end
    checks++;
    if (waited2 != 0) begin errors++; $display("FAIL b2b_gap: got %0d extra idle clocks need 0", waited2); end
    checks++;
    if (got2 !== 8'h81 || low2 != LOW_EXP || db != 0) begin
      errors++;
      $display("FAIL b2b_second: got %h low %0d dc errs %0d need 81 %0d 0", got2, low2, db, LOW_EXP);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, got;
    logic m;
    logic [8:0] exp;
    int rises, low, wb, mb, cb, db, waited;
    logic cs_after;
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom_range(0, 255));
      m = 1'($urandom_range(0, 1));
      exp_q.push_back({m, d});
      do_transfer(d, m, 1'b0, 1'b0, got, rises, low, wb, mb, cb, db, waited, cs_after);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp[7:0] || DC !== exp[8]) begin
        errors++;
        $display("FAIL random_byte[%0d]: got %h DC=%b need %h DC=%b", n, got, DC, exp[7:0], exp[8]);
      end
      checks++;
      if (low != LOW_EXP || wb != 0 || mb != 0 || cb != 0 || cs_after !== 1'b1) begin
        errors++;
        $display("FAIL random_timing[%0d]: got low %0d width %0d mosi %0d cs %0d cs_after %b need %0d 0 0 0 1",
                 n, low, wb, mb, cb, cs_after, LOW_EXP);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_pattern(8'hA5, 1'b1);
    test_pattern(8'h3C, 1'b0);
    test_data_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
